pong_game_control: RTL and testbench

PONG_GAME_CONTROL -- requirements
Module: pong_game_control

---
 rtl/pong_game_control.sv | 136 +++++++++++++
 tb/tb_pong_game_control.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_control.sv
// Pong referee: serve timing, miss detection against paddles, scoring and
// game-over arbitration for a ball controller that reports its position.
module pong_game_control #(
  parameter int GAME_WIDTH    = 40,
  parameter int GAME_HEIGHT   = 30,
  parameter int PADDLE_HEIGHT = 6,
  parameter int SCORE_LIMIT   = 9,
  parameter int SERVE_DELAY   = 25000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [5:0] ball_x,
  input  logic [5:0] ball_y,
  input  logic [5:0] paddle1_y,
  input  logic [5:0] paddle2_y,
  output logic       running,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       point_pulse,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    PLAY,
    POINT,
    GAME_OVER
  } state_t;

  localparam int CW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_DELAY - 1);
  localparam logic [3:0] LIMIT = 4'(SCORE_LIMIT);
  localparam logic [5:0] X_RIGHT = 6'(GAME_WIDTH - 1);
  localparam logic [6:0] SPAN = 7'(PADDLE_HEIGHT - 1);

  if (GAME_HEIGHT < PADDLE_HEIGHT || SCORE_LIMIT < 1 || SCORE_LIMIT > 15)
  begin : g_param_check
    $error("pong_game_control: illegal parameter combination");
  end

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0]    s1_d, s2_d;
  logic [1:0]    win_d;
  logic          start_q;
  logic [5:0]    ball_x_q;
  logic          start_edge, new_pos, hit1, hit2;
  logic [6:0]    by7, p1_7, p2_7;

  assign start_edge = start & ~start_q;
  assign new_pos    = ball_x != ball_x_q;

  // Widened so a paddle near row 63 cannot wrap its bottom edge.
  assign by7  = {1'b0, ball_y};
  assign p1_7 = {1'b0, paddle1_y};
  assign p2_7 = {1'b0, paddle2_y};
  assign hit1 = (by7 >= p1_7) && (by7 <= p1_7 + SPAN);
  assign hit2 = (by7 >= p2_7) && (by7 <= p2_7 + SPAN);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    s1_d    = score1;
    s2_d    = score2;
    win_d   = winner;
    unique case (state)
      IDLE, GAME_OVER: begin
        if (start_edge) begin
          s1_d    = '0;
          s2_d    = '0;
          win_d   = 2'b00;
          cnt_d   = '0;
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (cnt == CNT_LAST) state_d = PLAY;
        else cnt_d = cnt + CW'(1);
      end
      PLAY: begin
        if (new_pos) begin
          if (ball_x == 6'd0 && !hit1 && score2 < LIMIT) begin
            s2_d    = score2 + 4'd1;
            state_d = POINT;
          end else if (ball_x == X_RIGHT && !hit2 && score1 < LIMIT) begin
            s1_d    = score1 + 4'd1;
            state_d = POINT;
          end
        end
      end
      POINT: begin
        if (score1 == LIMIT) begin
          win_d   = 2'b01;
          state_d = GAME_OVER;
        end else if (score2 == LIMIT) begin
          win_d   = 2'b10;
          state_d = GAME_OVER;
        end else begin
          cnt_d   = '0;
          state_d = SERVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      score1      <= '0;
      score2      <= '0;
      winner      <= 2'b00;
      running     <= 1'b0;
      point_pulse <= 1'b0;
      game_over   <= 1'b0;
      start_q     <= 1'b0;
      ball_x_q    <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      score1      <= s1_d;
      score2      <= s2_d;
      winner      <= win_d;
      running     <= state_d == PLAY;
      point_pulse <= state_d == POINT;
      game_over   <= state_d == GAME_OVER;
      start_q     <= start;
      ball_x_q    <= ball_x;
    end
  end

endmodule

// File: tb/tb_pong_game_control.sv
// Bench for pong_game_control: directed game scenarios plus random play
// compared cycle by cycle against a rule-level referee model.
module tb_pong_game_control;

  localparam int W   = 40;
  localparam int H   = 30;
  localparam int PH  = 6;
  localparam int LIM = 3;
  localparam int SD  = 4;

  localparam int M_IDLE  = 0;
  localparam int M_SERVE = 1;
  localparam int M_PLAY  = 2;
  localparam int M_POINT = 3;
  localparam int M_OVER  = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] ball_x = 6'd20;
  logic [5:0] ball_y = 6'd0;
  logic [5:0] paddle1_y = 6'd0;
  logic [5:0] paddle2_y = 6'd0;
  logic       running;
  logic [3:0] score1, score2;
  logic       point_pulse, game_over;
  logic [1:0] winner;
  logic [12:0] dut_vec;

  int checks = 0;
  int errors = 0;

  int m_mode, m_left, m_s1, m_s2, m_win, m_prev_x;
  bit m_prev_start;

  always #5 clock = ~clock;

  assign dut_vec = {running, score1, score2, point_pulse, game_over, winner};

  pong_game_control #(
    .GAME_WIDTH(W), .GAME_HEIGHT(H), .PADDLE_HEIGHT(PH),
    .SCORE_LIMIT(LIM), .SERVE_DELAY(SD)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .ball_x(ball_x), .ball_y(ball_y),
    .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
    .running(running), .score1(score1), .score2(score2),
    .point_pulse(point_pulse), .game_over(game_over), .winner(winner)
  );

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_left = 0;
    m_s1 = 0;
    m_s2 = 0;
    m_win = 0;
    m_prev_x = 0;
    m_prev_start = 0;
  endfunction

  function automatic bit covers(int top, int y);
    return y >= top && y <= top + PH - 1;
  endfunction

  function automatic void model_clock();
    int bx, by;
    bit se, newp;
    bx = int'(ball_x);
    by = int'(ball_y);
    se = start && !m_prev_start;
    newp = bx != m_prev_x;
    case (m_mode)
      M_IDLE, M_OVER:
        if (se) begin
          m_s1 = 0; m_s2 = 0; m_win = 0;
          m_mode = M_SERVE; m_left = SD;
        end
      M_SERVE: begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = M_PLAY;
      end
      M_PLAY:
        if (newp && bx == 0 && !covers(int'(paddle1_y), by)) begin
          m_s2++; m_mode = M_POINT;
        end else if (newp && bx == W - 1 && !covers(int'(paddle2_y), by)) begin
          m_s1++; m_mode = M_POINT;
        end
      M_POINT:
        if (m_s1 == LIM) begin
          m_win = 1; m_mode = M_OVER;
        end else if (m_s2 == LIM) begin
          m_win = 2; m_mode = M_OVER;
        end else begin
          m_mode = M_SERVE; m_left = SD;
        end
      default: m_mode = M_IDLE;
    endcase
    m_prev_start = start;
    m_prev_x = bx;
  endfunction

  function automatic logic [12:0] exp_vec();
    return {m_mode == M_PLAY, 4'(m_s1), 4'(m_s2),
            m_mode == M_POINT, m_mode == M_OVER, 2'(m_win)};
  endfunction

  task automatic step();
    @(posedge clock);
    model_clock();
    @(negedge clock);
  endtask

  task automatic wait_play();
    for (int i = 0; i < 20 && m_mode != M_PLAY; i++) step();
  endtask

  task automatic p1_point();
    paddle2_y = 6'd0;
    ball_y = 6'd40;
    ball_x = 6'd38;
    step();
    ball_x = 6'd39;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    ball_x = 6'd20;
    repeat (2) @(negedge clock);
    model_reset();
    checks++;
    if (dut_vec !== 13'd0) begin
      errors++;
      $display("FAIL reset_state: got %h want 0", dut_vec);
    end
    reset_n = 1'b1;
    repeat (3) step();
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL idle_hold: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_serve();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (running !== 1'b0) begin
        errors++;
        $display("FAIL serve_wait[%0d]: running %b want 0", i, running);
      end
      step();
    end
    checks++;
    if (running !== 1'b1 || score1 !== 4'd0 || score2 !== 4'd0) begin
      errors++;
      $display("FAIL serve_done: running %b s %0d/%0d want 1 0/0",
               running, score1, score2);
    end
  endtask

  task automatic test_paddle1();
    paddle1_y = 6'd10;
    ball_y = 6'd12;
    ball_x = 6'd1;
    step();
    ball_x = 6'd0;
    step();
    checks++;
    if (running !== 1'b1 || point_pulse !== 1'b0 || score2 !== 4'd0) begin
      errors++;
      $display("FAIL p1_hit: run %b pulse %b s2 %0d want 1 0 0",
               running, point_pulse, score2);
    end
    ball_x = 6'd1;
    step();
    ball_y = 6'd16;
    ball_x = 6'd0;
    step();
    checks++;
    if (point_pulse !== 1'b1 || score2 !== 4'd1 || running !== 1'b0) begin
      errors++;
      $display("FAIL p1_miss: pulse %b s2 %0d run %b want 1 1 0",
               point_pulse, score2, running);
    end
    step();
    checks++;
    if (point_pulse !== 1'b0 || running !== 1'b0 ||
        dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL p1_after: got %h want %h", dut_vec, exp_vec());
    end
    wait_play();
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL p1_replay: running %b want 1", running);
    end
  endtask

  task automatic test_paddle2_edge();
    paddle2_y = 6'd58;
    ball_y = 6'd63;
    ball_x = 6'd38;
    step();
    ball_x = 6'd39;
    step();
    checks++;
    if (point_pulse !== 1'b0 || running !== 1'b1 || score1 !== 4'd0) begin
      errors++;
      $display("FAIL p2_wide_hit: pulse %b run %b s1 %0d want 0 1 0",
               point_pulse, running, score1);
    end
    ball_x = 6'd38;
    step();
    ball_y = 6'd0;
    ball_x = 6'd39;
    step();
    checks++;
    if (point_pulse !== 1'b1 || score1 !== 4'd1) begin
      errors++;
      $display("FAIL p2_miss: pulse %b s1 %0d want 1 1", point_pulse, score1);
    end
    step();
    wait_play();
  endtask

  task automatic test_game_over();
    p1_point();
    step();
    wait_play();
    checks++;
    if (score1 !== 4'd2 || score2 !== 4'd1) begin
      errors++;
      $display("FAIL go_pre: s %0d/%0d want 2/1", score1, score2);
    end
    start = 1'b1;
    step();
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL play_ignores_start: running %b want 1", running);
    end
    p1_point();
    step();
    checks++;
    if (game_over !== 1'b1 || winner !== 2'b01 || score1 !== 4'd3 ||
        running !== 1'b0) begin
      errors++;
      $display("FAIL game_over: go %b win %b s1 %0d run %b want 1 01 3 0",
               game_over, winner, score1, running);
    end
    repeat (5) step();
    checks++;
    if (game_over !== 1'b1 || winner !== 2'b01 || score1 !== 4'd3) begin
      errors++;
      $display("FAIL held_start: go %b win %b s1 %0d want 1 01 3",
               game_over, winner, score1);
    end
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (game_over !== 1'b0 || winner !== 2'b00 || score1 !== 4'd0 ||
        score2 !== 4'd0 || m_mode != M_SERVE || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL restart: got %h want %h", dut_vec, exp_vec());
    end
    wait_play();
  endtask

  task automatic test_hold_ball();
    int pulses;
    pulses = 0;
    paddle1_y = 6'd0;
    ball_y = 6'd40;
    ball_x = 6'd1;
    step();
    ball_x = 6'd0;
    repeat (30) begin
      step();
      if (point_pulse === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1 || score2 !== 4'd1) begin
      errors++;
      $display("FAIL hold_ball: pulses %0d s2 %0d want 1 1", pulses, score2);
    end
  endtask

  task automatic test_reset_mid_play();
    repeat (2) begin
      p1_point();
      step();
      wait_play();
    end
    checks++;
    if (score1 !== 4'd2 || score2 !== 4'd1 || running !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: s %0d/%0d run %b want 2/1 1",
               score1, score2, running);
    end
    reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec !== 13'd0) begin
      errors++;
      $display("FAIL mid_reset: got %h want 0", dut_vec);
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) step();
    checks++;
    if (dut_vec !== exp_vec() || running !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 5);
      case (r)
        0: ball_x = 6'd0;
        1: ball_x = 6'd1;
        2: ball_x = 6'd38;
        3: ball_x = 6'd39;
        default: ball_x = 6'($urandom_range(0, 63));
      endcase
      ball_y = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) paddle1_y = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) paddle2_y = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 599) == 0) begin
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_vec !== 13'd0) begin
          errors++;
          $display("FAIL rand_reset[%0d]: got %h want 0", c, dut_vec);
        end
        @(negedge clock);
        reset_n = 1'b1;
      end
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h", c, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_serve();
    test_paddle1();
    test_paddle2_edge();
    test_game_over();
    test_hold_ball();
    test_reset_mid_play();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
